cache_2way: RTL and testbench

CACHE_2WAY -- requirements
Module: cache_2way

---
 rtl/cache_pkg.sv | 24 ++
 rtl/cache_way.sv | 54 +++++
 rtl/cache_2way.sv | 184 ++++++++++++++++++
 tb/tb_cache_2way.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the two-way set-associative cache.
//   - default parameter values for address/data/set-index widths
//   - controller state enumeration
//   - line record (valid, tag, data) for the default geometry
package cache_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_SET_BITS   = 3;
    localparam int DEF_TAG_WIDTH  = DEF_ADDR_WIDTH - DEF_SET_BITS - 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WTHRU  = 2'd2
    } state_t;

    typedef struct packed {
        logic                      valid;
        logic [DEF_TAG_WIDTH-1:0]  tag;
        logic [DEF_DATA_WIDTH-1:0] data;
    } line_t;

endpackage

// File: rtl/cache_way.sv
// One way of the cache: per-set valid bit, tag and data word, a tag compare
// against the presented tag and a single write port.
// Ports:
//   clk, rst            clock, synchronous active-high reset (clears valid bits)
//   set_idx, tag        set being looked up / written and the tag to compare/store
//   wr_en, wr_data      write tag, data and valid=1 into set_idx
//   line_valid          valid bit of the addressed set
//   hit                 addressed line valid and its tag matches
//   line_data           data word of the addressed set
module cache_way
    import cache_pkg::*;
#(
    parameter int SET_BITS   = DEF_SET_BITS,
    parameter int TAG_WIDTH  = DEF_TAG_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SET_BITS-1:0]   set_idx,
    input  logic [TAG_WIDTH-1:0]  tag,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  line_valid,
    output logic                  hit,
    output logic [DATA_WIDTH-1:0] line_data
);

    localparam int SETS = 1 << SET_BITS;

    logic [SETS-1:0]       valid;
    logic [TAG_WIDTH-1:0]  tags  [SETS];
    logic [DATA_WIDTH-1:0] words [SETS];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[set_idx] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; valid gates their use.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[set_idx]  <= tag;
            words[set_idx] <= wr_data;
        end
    end

    assign line_valid = valid[set_idx];
    assign hit        = line_valid && (tags[set_idx] == tag);
    assign line_data  = words[set_idx];

endmodule

// File: rtl/cache_2way.sv
// Two-way set-associative, write-through, no-write-allocate cache with
// per-set LRU replacement and a blocking CPU interface.
// Ports:
//   clk, rst                                   clock, synchronous active-high reset
//   cpu_req, cpu_we, cpu_addr, cpu_wdata       CPU access (held while cpu_stall=1)
//   cpu_rdata, cpu_stall                       read-hit data, access not done
//   mem_req, mem_we, mem_addr, mem_wdata       memory request (registered)
//   mem_ack, mem_rdata                         one-cycle memory completion
//   hit_count, miss_count                      only with CACHE_STATS_EN defined
// Optional feature macro: CACHE_STATS_EN (hit/miss counters).
//
// state  | meaning
// IDLE   | lookup; read hits complete, misses/writes start a memory access
// REFILL | reading the missed word from memory, filled into the victim way
// WTHRU  | writing the CPU word through to memory
module cache_2way
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int SET_BITS   = DEF_SET_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);

    localparam int TAG_WIDTH = ADDR_WIDTH - SET_BITS - 2;
    localparam int SETS      = 1 << SET_BITS;

    state_t                state;
    logic [SETS-1:0]       lru;      // per set: index of the least-recently-used way
    logic                  wr_done;  // write-through just acked; complete the held write

    logic [SET_BITS-1:0]   set_idx;
    logic [TAG_WIDTH-1:0]  tag;
    logic                  unused_byte_bits;
    logic                  v0, v1, hit0, hit1, hit_any, victim;
    logic [DATA_WIDTH-1:0] d0, d1, way_wdata;
    logic                  idle, rd_hit, wr_hit, refill_done, wr_en0, wr_en1;

    assign set_idx          = cpu_addr[SET_BITS+1:2];
    assign tag              = cpu_addr[ADDR_WIDTH-1:SET_BITS+2];
    assign unused_byte_bits = ^cpu_addr[1:0];

    assign idle        = (state == IDLE);
    assign hit_any     = hit0 || hit1;
    assign rd_hit      = idle && cpu_req && !cpu_we && hit_any;
    assign wr_hit      = idle && cpu_req && cpu_we && !wr_done && hit_any;
    assign refill_done = (state == REFILL) && mem_ack;

    // Fill an invalid way first (way0 before way1), otherwise the LRU way.
    assign victim = !v0 ? 1'b0 : (!v1 ? 1'b1 : lru[set_idx]);

    assign way_wdata = (state == REFILL) ? mem_rdata : cpu_wdata;
    assign wr_en0    = !rst && ((wr_hit && hit0) || (refill_done && !victim));
    assign wr_en1    = !rst && ((wr_hit && hit1) || (refill_done && victim));

    assign cpu_rdata = rd_hit ? (hit0 ? d0 : d1) : '0;
    assign cpu_stall = !idle || (cpu_req && (cpu_we ? !wr_done : !hit_any));

    cache_way #(
        .SET_BITS  (SET_BITS),
        .TAG_WIDTH (TAG_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_way0 (
        .clk       (clk),
        .rst       (rst),
        .set_idx   (set_idx),
        .tag       (tag),
        .wr_en     (wr_en0),
        .wr_data   (way_wdata),
        .line_valid(v0),
        .hit       (hit0),
        .line_data (d0)
    );

    cache_way #(
        .SET_BITS  (SET_BITS),
        .TAG_WIDTH (TAG_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_way1 (
        .clk       (clk),
        .rst       (rst),
        .set_idx   (set_idx),
        .tag       (tag),
        .wr_en     (wr_en1),
        .wr_data   (way_wdata),
        .line_valid(v1),
        .hit       (hit1),
        .line_data (d1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lru       <= '0;
            wr_done   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            wr_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        if (cpu_we) begin
                            if (!wr_done) begin
                                state     <= WTHRU;
                                mem_req   <= 1'b1;
                                mem_we    <= 1'b1;
                                mem_addr  <= {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
                                mem_wdata <= cpu_wdata;
                                if (hit_any) lru[set_idx] <= hit0;
                            end
                        end else if (hit_any) begin
                            // hit in way0 makes way1 least recent, and vice versa
                            lru[set_idx] <= hit0;
                        end else begin
                            state    <= REFILL;
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
                        end
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        state        <= IDLE;
                        mem_req      <= 1'b0;
                        lru[set_idx] <= ~victim;
                    end
                end
                WTHRU: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        wr_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    // The retried read that completes a refill is counted as the miss only.
    logic retry;
    logic miss_start;

    assign miss_start = idle && cpu_req && !cpu_we && !hit_any;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
            retry      <= 1'b0;
        end else begin
            retry <= refill_done;
            if (rd_hit && !retry) hit_count  <= hit_count + 32'd1;
            if (miss_start)       miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_2way.sv
// Self-checking bench for cache_2way: directed scenarios followed by random
// accesses, checked by a scoreboard against a recency-list cache model.
// Counter checks are compiled in only when CACHE_STATS_EN is defined.
module tb_cache_2way;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    cache_2way dut (
        .clk      (clk),
        .rst      (rst),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata)
`ifdef CACHE_STATS_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    typedef struct {
        bit          we;
        bit          hit;
        logic [31:0] rdata;
    } exp_t;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    exp_t exp_q[$];
    wr_t  wr_q[$];

    // Reference model: memory image plus, per set, up to two resident words
    // kept in recency order (index 0 = most recently used).
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] bus_mem [logic [31:0]];
    logic [31:0] m_addr [8][2];
    logic [31:0] m_data [8][2];
    int          m_n [8];
    int          n_hits = 0;
    int          n_misses = 0;

    bit auto_mem = 1'b1;
    bit mon_en   = 1'b1;
    int wait_left = -1;
    int last_ack_cyc = -10;
    int stalls = 0;

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic summary();
        $display("%0d/%0d checks passed", passes, checks);
    endtask

    task automatic fail_abort(input string name);
        checks++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
        summary();
        $finish;
    endtask

    task automatic touch(input int s, input int pos);
        logic [31:0] ta, td;
        if (pos == 1) begin
            ta = m_addr[s][0]; td = m_data[s][0];
            m_addr[s][0] = m_addr[s][1]; m_data[s][0] = m_data[s][1];
            m_addr[s][1] = ta; m_data[s][1] = td;
        end
    endtask

    task automatic model_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                                output bit hit, output logic [31:0] rdata);
        int s, pos;
        logic [31:0] a;
        wr_t w;
        a = {addr[31:2], 2'b00};
        s = int'(addr[4:2]);
        hit = 1'b0; pos = 0; rdata = '0;
        for (int i = 0; i < m_n[s]; i++)
            if (m_addr[s][i] == a) begin hit = 1'b1; pos = i; end
        if (we) begin
            ref_mem[a] = wdata;
            w.addr = a; w.data = wdata;
            wr_q.push_back(w);
            if (hit) begin m_data[s][pos] = wdata; touch(s, pos); end
        end else if (hit) begin
            rdata = m_data[s][pos];
            touch(s, pos);
            n_hits++;
        end else begin
            rdata = ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
            m_addr[s][1] = m_addr[s][0]; m_data[s][1] = m_data[s][0];
            m_addr[s][0] = a;            m_data[s][0] = rdata;
            if (m_n[s] < 2) m_n[s]++;
            n_misses++;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_n[i] = 0;
        n_hits = 0;
        n_misses = 0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the access completed.
    task automatic issue(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        bit h;
        logic [31:0] rd;
        int n;
        model_access(we, addr, wdata, h, rd);
        e.we = we; e.hit = we ? 1'b0 : h; e.rdata = rd;
        exp_q.push_back(e);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cpu_stall && n < 200);
        if (cpu_stall) fail_abort("access_timeout");
        @(posedge clk);
        #1;
        cpu_req = 1'b0; cpu_we = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_stall", {31'd0, cpu_stall}, 32'd0);
            check("idle_mem_req", {31'd0, mem_req}, 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every completed CPU access is compared with the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en && cpu_req) begin
                if (cpu_stall) begin
                    stalls++;
                end else if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL sb_unexpected: completion with empty scoreboard at cycle %0d", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check(e.we ? "wr_rdata_zero" : "rd_data", cpu_rdata, e.rdata);
                    check("hit_no_stall", {31'd0, stalls == 0}, {31'd0, e.hit});
                    if (stalls != 0) check("done_after_ack", cyc, last_ack_cyc + 1);
                    stalls = 0;
                end
            end else begin
                stalls = 0;
            end
        end
    end

    // Memory responder with random latency; checks every memory transaction.
    initial begin
        wr_t w;
        forever begin
            @(negedge clk);
            if (auto_mem) begin
                mem_ack = 1'b0;
                if (mem_req) begin
                    if (wait_left < 0) wait_left = $urandom_range(0, 3);
                    if (wait_left == 0) begin
                        wait_left = -1;
                        mem_ack = 1'b1;
                        last_ack_cyc = cyc;
                        check("mem_we", {31'd0, mem_we}, {31'd0, cpu_we});
                        if (mem_we) begin
                            if (wr_q.size() == 0) begin
                                checks++;
                                $display("FAIL mem_wr_unexpected: addr %h at cycle %0d", mem_addr, cyc);
                            end else begin
                                w = wr_q.pop_front();
                                check("mem_wr_addr", mem_addr, w.addr);
                                check("mem_wdata", mem_wdata, w.data);
                            end
                            bus_mem[mem_addr] = mem_wdata;
                        end else begin
                            check("refill_addr", mem_addr, {cpu_addr[31:2], 2'b00});
                            mem_rdata = bus_mem.exists(mem_addr) ? bus_mem[mem_addr] : mem_init(mem_addr);
                        end
                    end else begin
                        wait_left--;
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] a;
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_stall", {31'd0, cpu_stall}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_rdata", cpu_rdata, 32'd0);
`ifdef CACHE_STATS_EN
        check("rst_hit_count", hit_count, 32'd0);
        check("rst_miss_count", miss_count, 32'd0);
`endif
        @(posedge clk);
        #1;

        // First read miss, refill with a known word, then the retry hits.
        ref_mem[32'h40] = 32'hDEAD_BEEF;
        bus_mem[32'h40] = 32'hDEAD_BEEF;
        issue(1'b0, 32'h40, '0);
        issue(1'b0, 32'h40, '0);
`ifdef CACHE_STATS_EN
        check("hit_count", hit_count, n_hits);
        check("miss_count", miss_count, n_misses);
`endif
        idle_cycles(2);

        // LRU replacement within set 0.
        issue(1'b0, 32'h140, '0);
        issue(1'b0, 32'h240, '0);
        issue(1'b0, 32'h140, '0);
        issue(1'b0, 32'h40, '0);

        // Write hit updates the cached copy; write miss does not allocate.
        issue(1'b1, 32'h40, 32'h1234_5678);
        issue(1'b0, 32'h40, '0);
        issue(1'b1, 32'h80, 32'hCAFE_F00D);
        issue(1'b0, 32'h80, '0);
        idle_cycles(1);

        // Reset arriving together with the refill acknowledge.
        mon_en = 1'b0;
        auto_mem = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h300;
        @(negedge clk);
        check("miss_stall", {31'd0, cpu_stall}, 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("refill_req", {31'd0, mem_req}, 32'd1);
        check("refill_req_addr", mem_addr, 32'h300);
        mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0; rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; mem_ack = 1'b0; cpu_req = 1'b0;
        @(negedge clk);
        check("abort_mem_req", {31'd0, mem_req}, 32'd0);
        model_reset();
        wait_left = -1;
        auto_mem = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        issue(1'b0, 32'h300, '0);

        // Random traffic over a few tags per set to force conflicts.
        for (int t = 0; t < 300; t++) begin
            a = ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 9) < 3) issue(1'b1, a, $urandom);
            else issue(1'b0, a, '0);
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
        end

        idle_cycles(1);
`ifdef CACHE_STATS_EN
        check("final_hit_count", hit_count, n_hits);
        check("final_miss_count", miss_count, n_misses);
`endif
        check("sb_drained", exp_q.size(), 32'd0);
        check("wr_q_drained", wr_q.size(), 32'd0);
        summary();
        $finish;
    end

    initial begin
        #2_000_000;
        fail_abort("global_timeout");
    end

endmodule
